// File: rtl/acc_stack.sv
// Accumulator register with a small LIFO save stack for context save/restore.
// Optional sticky overflow/underflow flags are built when ACC_STACK_ERR_EN is defined.
module acc_stack #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clb,
    input  logic              load_acc,
    input  logic [1:0]        sel_src,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IMM_W-1:0]  immediate,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_zero,
    output logic [DATA_W-1:0] stk_top,
    output logic [CNT_W-1:0]  stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        SRC_ALU   = 2'b00,
        SRC_DATA  = 2'b01,
        SRC_IMM   = 2'b10,
        SRC_STACK = 2'b11
    } src_e;

    logic [DATA_W-1:0] r_stack [DEPTH];
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_full;
    logic              w_empty;
    logic [IDX_W-1:0]  w_top_idx;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_acc_src;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_full    = (r_cnt == FULL_CNT);
    assign w_empty   = (r_cnt == '0);
    assign w_top_idx = IDX_W'(r_cnt - CNT_W'(1));
    assign w_top     = w_empty ? '0 : r_stack[w_top_idx];

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        w_acc_src = alu_out;
        case (src_e'(sel_src))
            SRC_ALU:   w_acc_src = alu_out;
            SRC_DATA:  w_acc_src = data_in;
            SRC_IMM:   w_acc_src = DATA_W'(immediate);
            SRC_STACK: w_acc_src = w_top;
            default:   w_acc_src = alu_out;
        endcase
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = IDX_W'(r_cnt);
        w_cnt_nxt = r_cnt;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        case ({push, pop})
            2'b11: begin
                // Swap-save overwrites the top in place; on an empty stack it is a plain push.
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_wr_idx = w_top_idx;
                end
            end
            2'b10: begin
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clb) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!clb) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            if (load_acc) r_acc <= w_acc_src;
            r_cnt <= w_cnt_nxt;
        end
    end

    // NOTE: storage has no reset; entries above stk_cnt are never observed.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_stack[w_wr_idx] <= r_acc;
    end

`ifdef ACC_STACK_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt)    r_ovf <= 1'b1;
            else if (err_clr) r_ovf <= 1'b0;
            if (w_unf_evt)    r_unf <= 1'b1;
            else if (err_clr) r_unf <= 1'b0;
        end
    end

    assign ovf_err = r_ovf;
    assign unf_err = r_unf;
`else
    logic w_unused_err;
    assign w_unused_err = &{1'b0, err_clr, w_ovf_evt, w_unf_evt};
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

    assign acc_out   = r_acc;
    assign acc_zero  = (r_acc == '0);
    assign stk_top   = w_top;
    assign stk_cnt   = r_cnt;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;

endmodule

// File: tb/tb_acc_stack.sv
// Directed self-checking bench for acc_stack; error-flag expectations follow ACC_STACK_ERR_EN.
module tb_acc_stack;

`ifdef ACC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clb;
    logic       load_acc;
    logic [1:0] sel_src;
    logic [7:0] alu_out;
    logic [7:0] data_in;
    logic [3:0] immediate;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [7:0] acc_out;
    logic       acc_zero;
    logic [7:0] stk_top;
    logic [2:0] stk_cnt;
    logic       stk_full;
    logic       stk_empty;
    logic       ovf_err;
    logic       unf_err;

    int checks   = 0;
    int failures = 0;

    acc_stack dut (
        .clk       (clk),
        .clb       (clb),
        .load_acc  (load_acc),
        .sel_src   (sel_src),
        .alu_out   (alu_out),
        .data_in   (data_in),
        .immediate (immediate),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .acc_out   (acc_out),
        .acc_zero  (acc_zero),
        .stk_top   (stk_top),
        .stk_cnt   (stk_cnt),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        load_acc  = 1'b0;
        sel_src   = 2'b00;
        alu_out   = 8'h00;
        data_in   = 8'h00;
        immediate = 4'h0;
        push      = 1'b0;
        pop       = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Apply one cycle of stimulus, sample 1 time unit after the edge, then go idle.
    task automatic cyc(input logic ld, input logic [1:0] sel, input logic [7:0] din,
                       input logic [3:0] imm, input logic ps, input logic pp, input logic clr);
        load_acc  = ld;
        sel_src   = sel;
        data_in   = din;
        alu_out   = ~din;
        immediate = imm;
        push      = ps;
        pop       = pp;
        err_clr   = clr;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        set_idle();
        clb = 1'b0;
        #1;
        check("rst_acc",   acc_out,   0);
        check("rst_zero",  acc_zero,  1);
        check("rst_empty", stk_empty, 1);
        check("rst_full",  stk_full,  0);
        check("rst_top",   stk_top,   0);
        check("rst_cnt",   stk_cnt,   0);
        check("rst_ovf",   ovf_err,   0);
        check("rst_unf",   unf_err,   0);
        #11 clb = 1'b1;

        // Immediate load, zero-extended
        cyc(1, 2'b10, 8'h00, 4'hA, 0, 0, 0);
        check("imm_acc",  acc_out,  8'h0A);
        check("imm_zero", acc_zero, 0);

        // ALU source
        cyc(1, 2'b00, 8'h0F, 4'h0, 0, 0, 0);
        check("alu_acc", acc_out, 8'hF0);

        // Fill the stack
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'b01, vals[i], 4'h0, 0, 0, 0);
            check("fill_acc", acc_out, vals[i]);
            cyc(0, 2'b00, 8'h00, 4'h0, 1, 0, 0);
            check("fill_cnt", stk_cnt, i + 1);
            check("fill_top", stk_top, vals[i]);
        end
        check("full_flag", stk_full, 1);
        cyc(0, 2'b00, 8'h00, 4'h0, 1, 0, 0);
        check("ovf_flag", ovf_err, ERR_EN);
        check("ovf_top",  stk_top, 8'h44);
        check("ovf_cnt",  stk_cnt, 4);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 0, 1);
        check("ovf_clr", ovf_err, 0);

        // Restore: load from top while popping
        for (int i = 3; i >= 0; i--) begin
            cyc(1, 2'b11, 8'h00, 4'h0, 0, 1, 0);
            check("rest_acc", acc_out, vals[i]);
            check("rest_cnt", stk_cnt, i);
        end
        check("rest_empty", stk_empty, 1);
        check("rest_top",   stk_top,   0);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 1, 0);
        check("unf_flag", unf_err, ERR_EN);
        check("unf_acc",  acc_out, 8'h11);
        check("unf_cnt",  stk_cnt, 0);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 1, 1);
        check("unf_clr_race", unf_err, ERR_EN);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 0, 1);
        check("unf_clr", unf_err, 0);

        // Swap-save: acc=55, top=22 -> acc=22, top=55
        cyc(0, 2'b00, 8'h00, 4'h0, 1, 0, 0);
        cyc(1, 2'b01, 8'h22, 4'h0, 0, 0, 0);
        cyc(0, 2'b00, 8'h00, 4'h0, 1, 0, 0);
        cyc(1, 2'b01, 8'h55, 4'h0, 0, 0, 0);
        check("swap_pre_top", stk_top, 8'h22);
        cyc(1, 2'b11, 8'h00, 4'h0, 1, 1, 0);
        check("swap_acc", acc_out, 8'h22);
        check("swap_top", stk_top, 8'h55);
        check("swap_cnt", stk_cnt, 2);
        check("swap_ovf", ovf_err, 0);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 1, 0);
        check("swap_below", stk_top, 8'h11);
        cyc(0, 2'b00, 8'h00, 4'h0, 0, 1, 0);
        check("drain_cnt", stk_cnt, 0);

        // Push+pop on empty acts as push, no error
        cyc(0, 2'b00, 8'h00, 4'h0, 1, 1, 0);
        check("pp_empty_cnt", stk_cnt, 1);
        check("pp_empty_top", stk_top, 8'h22);
        check("pp_empty_unf", unf_err, 0);

        // Load with push stores the old accumulator
        cyc(1, 2'b01, 8'h66, 4'h0, 1, 0, 0);
        check("ldpush_acc", acc_out, 8'h66);
        check("ldpush_top", stk_top, 8'h22);
        check("ldpush_cnt", stk_cnt, 2);

        // Asynchronous reset between edges with cnt=3, acc=7F
        cyc(0, 2'b00, 8'h00, 4'h0, 1, 0, 0);
        cyc(1, 2'b01, 8'h7F, 4'h0, 0, 0, 0);
        check("pre_rst_cnt", stk_cnt, 3);
        check("pre_rst_acc", acc_out, 8'h7F);
        #2 clb = 1'b0;
        #1;
        check("arst_acc",   acc_out,   0);
        check("arst_cnt",   stk_cnt,   0);
        check("arst_zero",  acc_zero,  1);
        check("arst_empty", stk_empty, 1);
        check("arst_top",   stk_top,   0);
        #2 clb = 1'b1;
        cyc(1, 2'b10, 8'h00, 4'h3, 0, 0, 0);
        check("post_rst_acc", acc_out, 8'h03);
        check("post_rst_cnt", stk_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
